// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC control with redirect buffering, stall hold and sticky halt
module pc_sequencer #(
    parameter logic [31:0] PC0 = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] pc_cur,
    input  logic        ihit,
    input  logic        stall,
    input  logic        halt,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] pc_in,
    output logic        pc_WEN,
    output logic        imemREN,
    output logic        flush,
    output logic        halted,
    output logic        pend_valid,
    output logic [31:0] pend_addr
);
    typedef enum logic [1:0] {RUN, HOLD, HALT} state_t;
    state_t      state;
    logic        adv;
    logic        redir;
    logic [31:0] tgt;
    logic [31:0] inc;
    assign adv   = ihit & ~stall;
    assign redir = jmp | br_taken;
    assign tgt   = (jmp ? jmp_target : br_target) & ~32'h3;
    assign inc   = pc_cur + 32'd4;
    // counter drive: a write only when the fetch slot advances and we are not halting or in reset
    always_comb begin
        pc_in  = inc;
        pc_WEN = 1'b0;
        flush  = 1'b0;
        if (!RST && !halt && adv && state == RUN) begin
            pc_in  = redir ? tgt : inc;
            pc_WEN = 1'b1;
            flush  = redir;
        end else if (!RST && !halt && adv && state == HOLD) begin
            pc_in  = pend_addr;
            pc_WEN = 1'b1;
            flush  = 1'b1;
        end
    end
    // state, redirect buffer and halt flags; HALT is left only through reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= RUN;
            pend_valid <= 1'b0;
            pend_addr  <= PC0;
            halted     <= 1'b0;
            imemREN    <= 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (halt) begin
                        state   <= HALT;
                        halted  <= 1'b1;
                        imemREN <= 1'b0;
                    end else if (redir && !adv) begin
                        state      <= HOLD;
                        pend_valid <= 1'b1;
                        pend_addr  <= tgt;
                    end
                end
                HOLD: begin
                    if (halt) begin
                        state      <= HALT;
                        pend_valid <= 1'b0;
                        halted     <= 1'b1;
                        imemREN    <= 1'b0;
                    end else if (adv) begin
                        state      <= RUN;
                        pend_valid <= 1'b0;
                    end
                end
                default: begin
                    state   <= HALT;
                    halted  <= 1'b1;
                    imemREN <= 1'b0;
                end
            endcase
        end
    end
endmodule
